fcvt_float_to_int: RTL
======================

// Module: fcvt_float_to_int
// PURPOSE
// - Sequential FP32 -> 32-bit integer converter for RISC-V FCVT.W.S / FCVT.WU.S.
// - Covers all five IEEE rounding modes, saturation, and the NV/NX exception flags.
// - Inverse of the int->float path in the FP datapath; started by the execute stage.
// - Holds the pipeline via busy until done pulses.
// PARAMETERS
// - INT_W   32  integer result width; only 32 is supported (elaboration assert).
// - EXP_W    8  FP32 exponent width.
// - FRAC_W  23  FP32 fraction width.
// PORTS
// - clk          in   1   clock; all state on posedge.
// - rst          in   1   reset; asynchronous, active-high.
// - start        in   1   request; accepted only in IDLE.
// - is_unsigned  in   1   1 = FCVT.WU.S, 0 = FCVT.W.S; captured at accept.
// - rm           in   3   rounding mode (rm_t); captured at accept.
// - operand      in   32  FP32 source; captured at accept.
// - busy         out  1   high whenever state != IDLE.
// - done         out  1   one-cycle pulse; result and flags are valid.
// - result       out  32  integer result; held until the next accept.
// - invalid      out  1   NV flag; held with result.
// - inexact      out  1   NX flag; held with result.
// BEHAVIOUR
// - Reset: state=IDLE; busy=done=invalid=inexact=0; result=0.
// - Reset mid-operation: abort immediately; no done is issued.
// - States: IDLE -> SHIFT -> ROUND -> SAT -> DONE -> IDLE.
// - Specials jump IDLE -> DONE directly.
// - Accept (IDLE & start): capture sign s, is_unsigned, rm. Unbiased exponent E = exp - 127.
// - 64-bit acc: integer part in [63:32], fraction in [31:0]. Sticky register is cleared at accept.
// - NaN: result=max positive (0x7FFFFFFF signed / 0xFFFFFFFF unsigned), invalid=1 -> DONE.
// - Inf, or E>=32: saturate by sign, invalid=1 -> DONE.
// - Saturation values: signed 0x7FFFFFFF / 0x80000000; unsigned 0xFFFFFFFF / 0x0.
// - Zero: result=0, flags=0 -> DONE.
// - Subnormal: acc=0, sticky=(frac!=0), cnt=0 -> SHIFT.
// - E < -33: acc=0, sticky=1, cnt=0 -> SHIFT.
// - Otherwise: acc={31'b0,1'b1,frac,9'b0}, cnt=|E|, dir=sign(E) -> SHIFT.
// - SHIFT: if cnt!=0, shift acc by 1 (left for E>0, right for E<0) and cnt--.
//   Right shifts OR the outgoing bit into sticky. When cnt==0 -> ROUND.
//   Time spent in SHIFT = cnt+1 cycles.
// - ROUND: lsb=acc[32], g=acc[31], r=|acc[30:0]|sticky.
// - Round increment by mode:
//   RNE: g&(r|lsb); RTZ: 0; RDN: s&(g|r); RUP: ~s&(g|r); RMM: g.
//   rm 101/110/111 are treated as RNE; DYN is resolved upstream.
// - ROUND output: mag[32:0] = acc[63:32] + inc; nx = g|r.
// - SAT: range check on the 33-bit mag.
//   Signed: s=0 requires mag<=2^31-1; s=1 requires mag<=2^31.
//   Unsigned: s=0 requires mag<=2^32-1; s=1 requires mag==0.
// - In range: result = s ? -mag : mag; invalid=0; inexact=nx.
// - Out of range: saturate by sign; invalid=1; inexact=0 (NV only).
// - DONE: done=1 for exactly one cycle -> IDLE. result and flags stay stable until the next accept.
// - Latency from accept cycle T: done at T+cnt+4; specials at T+1.
//   Worst case: T+37 (E=-33).
// - start while busy (including DONE) is ignored and not queued.
// - A back-to-back start is accepted in the IDLE cycle after DONE.
// STRUCTURE
// - fpu_pkg (shared): typedef enum logic[2:0] rm_t {RNE,RTZ,RDN,RUP,RMM};
//   FP32_BIAS=127, EXP_W, FRAC_W; INT32_MAX/INT32_MIN/UINT32_MAX constants.
// - State enum is local to this module.
// - One sub-module, fcvt_round_inc: combinational (rm, s, lsb, g, r) -> inc.
//   Kept separate for reuse by int->float rounding.
// TESTING
// - 0x40600000 (3.5), signed, RNE -> 0x00000004, NX=1, NV=0, done exactly at T+5.
// - 0xC0200000 (-2.5), signed, each rm:
//   RNE -> 0xFFFFFFFE; RTZ -> 0xFFFFFFFE; RDN -> 0xFFFFFFFD; RUP -> 0xFFFFFFFE; RMM -> 0xFFFFFFFD.
//   NX=1 in all modes.
// - 0x4F000000 (2^31): signed -> 0x7FFFFFFF NV=1; unsigned -> 0x80000000 NV=0.
//   0xCF000000 signed -> 0x80000000 exact, flags 0.
// - 0x7FC00000 (NaN), signed -> 0x7FFFFFFF NV=1, done at T+1.
//   0xFF800000 (-inf), unsigned -> 0x0 NV=1.
// - 0x00000001, unsigned, RUP -> 1, NX=1.
//   0xBE99999A (-0.3), unsigned: RTZ -> 0, NX=1, NV=0; RDN -> 0, NV=1, NX=0.
// - Stress: reset during SHIFT of 0x4E6E6B28 -> outputs 0 at once, no done.
//   start while busy is ignored; back-to-back starts give correct results.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FP datapath definitions: rounding modes, FP32 field widths and
// the integer saturation constants used by the float<->int converters.
package fpu_pkg;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int FP32_BIAS = 127;

  // RISC-V static rounding modes; DYN is resolved before reaching the FPU.
  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rm_t;

  localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
  localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/fcvt_round_inc.sv
// Rounding-increment decision shared by the float->int and int->float paths.
// Given the kept LSB, guard bit and round/sticky bit, decides whether the
// truncated magnitude must be bumped by one ulp.
module fcvt_round_inc (
  input  logic [2:0] rm,
  input  logic       s,
  input  logic       lsb,
  input  logic       g,
  input  logic       r,
  output logic       inc
);

  import fpu_pkg::*;

  // Reserved encodings fall back to round-to-nearest-even.
  always_comb begin
    inc = g & (r | lsb);
    case (rm)
      RNE:     inc = g & (r | lsb);
      RTZ:     inc = 1'b0;
      RDN:     inc = s & (g | r);
      RUP:     inc = ~s & (g | r);
      RMM:     inc = g;
      default: inc = g & (r | lsb);
    endcase
  end

endmodule

// File: rtl/fcvt_float_to_int.sv
// Sequential FP32 -> 32-bit integer converter (FCVT.W.S / FCVT.WU.S).
// The operand is aligned one bit per cycle in a 64-bit fixed-point
// accumulator (integer part [63:32], fraction [31:0]), rounded with the
// requested mode, then range-checked and saturated. Specials (NaN, Inf,
// zero, magnitudes >= 2^32) bypass the datapath and finish in one cycle.
module fcvt_float_to_int #(
  parameter int INT_W  = 32,
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_unsigned,
  input  logic [2:0]       rm,
  input  logic [31:0]      operand,
  output logic             busy,
  output logic             done,
  output logic [INT_W-1:0] result,
  output logic             invalid,
  output logic             inexact
);

  import fpu_pkg::*;

  if (INT_W != 32) begin : g_bad_int_w
    $error("fcvt_float_to_int: only INT_W == 32 is supported");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_ROUND = 3'd2,
    S_SAT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Saturated value chosen by the sign of the source.
  function automatic logic [31:0] sat_value(input logic neg, input logic uns);
    if (uns) return neg ? 32'h0000_0000 : UINT32_MAX;
    else     return neg ? INT32_MIN : INT32_MAX;
  endfunction

  // Whether a rounded 33-bit magnitude fits the destination integer type.
  function automatic logic mag_in_range(input logic [32:0] mag_v, input logic neg,
                                        input logic uns);
    if (uns) return neg ? (mag_v == 33'd0) : (mag_v <= 33'h0_FFFF_FFFF);
    else     return neg ? (mag_v <= 33'h0_8000_0000) : (mag_v <= 33'h0_7FFF_FFFF);
  endfunction

  // Operand decode
  logic [EXP_W-1:0]  op_exp;
  logic [FRAC_W-1:0] op_frac;
  logic              op_sign;
  logic              frac_nz;
  logic              exp_max;
  logic signed [9:0] op_e;

  assign op_exp  = operand[FRAC_W +: EXP_W];
  assign op_frac = operand[FRAC_W-1:0];
  assign op_sign = operand[31];
  assign frac_nz = |op_frac;
  assign exp_max = &op_exp;
  assign op_e    = $signed({2'b00, op_exp}) - $signed(10'(FP32_BIAS));

  // Special-case results and the initial accumulator load
  logic        spec_hit;
  logic [31:0] spec_res;
  logic        spec_nv;
  logic [63:0] ld_acc;
  logic        ld_sticky;
  logic [5:0]  ld_cnt;
  logic        ld_left;

  // Datapath state
  logic [63:0] acc;
  logic        sticky;
  logic [5:0]  cnt;
  logic        left;
  logic        sgn;
  logic        uns;
  logic [2:0]  rm_q;
  logic [32:0] mag;
  logic        nx;

  // Rounding and saturation signals
  logic        rnd_lsb;
  logic        rnd_g;
  logic        rnd_r;
  logic        rnd_inc;
  logic        in_range;
  logic [31:0] sat_res;
  logic        accept;

  assign accept = (state == S_IDLE) && start;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

  // Classify the operand at accept time and prepare the accumulator load.
  always_comb begin
    spec_hit  = 1'b0;
    spec_res  = 32'h0000_0000;
    spec_nv   = 1'b0;
    ld_acc    = {31'b0, 1'b1, op_frac, 9'b0};
    ld_sticky = 1'b0;
    ld_cnt    = 6'(op_e[9] ? -op_e : op_e);
    ld_left   = ~op_e[9];
    if (exp_max && frac_nz) begin
      // NaN converts to the largest positive value of the destination.
      spec_hit = 1'b1;
      spec_res = is_unsigned ? UINT32_MAX : INT32_MAX;
      spec_nv  = 1'b1;
    end else if (exp_max || (op_e >= 10'sd32)) begin
      spec_hit = 1'b1;
      spec_res = sat_value(op_sign, is_unsigned);
      spec_nv  = 1'b1;
    end else if (op_exp == '0) begin
      if (!frac_nz) begin
        spec_hit = 1'b1;
      end else begin
        // Subnormals are far below one half: only sticky survives.
        ld_acc    = 64'd0;
        ld_sticky = 1'b1;
        ld_cnt    = 6'd0;
      end
    end else if (op_e < -10'sd33) begin
      // Too small for the hidden bit to reach the guard position.
      ld_acc    = 64'd0;
      ld_sticky = 1'b1;
      ld_cnt    = 6'd0;
    end
  end

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state sequencing: IDLE -> SHIFT -> ROUND -> SAT -> DONE, specials skip to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = spec_hit ? S_DONE : S_SHIFT;
      S_SHIFT: if (cnt == 6'd0) state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_SAT;
      S_SAT:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rnd_lsb = acc[32];
  assign rnd_g   = acc[31];
  assign rnd_r   = (|acc[30:0]) | sticky;

  fcvt_round_inc u_round_inc (
    .rm  (rm_q),
    .s   (sgn),
    .lsb (rnd_lsb),
    .g   (rnd_g),
    .r   (rnd_r),
    .inc (rnd_inc)
  );

  // Capture at accept, align one bit per cycle, then form the rounded magnitude.
  always_ff @(posedge clk) begin
    if (accept) begin
      sgn    <= op_sign;
      uns    <= is_unsigned;
      rm_q   <= rm;
      acc    <= ld_acc;
      sticky <= ld_sticky;
      cnt    <= ld_cnt;
      left   <= ld_left;
    end else if ((state == S_SHIFT) && (cnt != 6'd0)) begin
      if (left) begin
        acc <= acc << 1;
      end else begin
        acc    <= acc >> 1;
        sticky <= sticky | acc[0];
      end
      cnt <= cnt - 6'd1;
    end else if (state == S_ROUND) begin
      mag <= {1'b0, acc[63:32]} + {32'b0, rnd_inc};
      nx  <= rnd_g | rnd_r;
    end
  end

  assign in_range = mag_in_range(mag, sgn, uns);
  assign sat_res  = in_range ? (sgn ? (~mag[31:0] + 32'd1) : mag[31:0])
                             : sat_value(sgn, uns);

  // Architectural result and flags; held until the next conversion writes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      invalid <= 1'b0;
      inexact <= 1'b0;
    end else if (accept && spec_hit) begin
      result  <= spec_res;
      invalid <= spec_nv;
      inexact <= 1'b0;
    end else if (state == S_SAT) begin
      // An out-of-range result raises NV only, never NX.
      result  <= sat_res;
      invalid <= ~in_range;
      inexact <= in_range & nx;
    end
  end

endmodule
